// File: rtl/scene_sequencer.sv
// Day/night timeline controller for the twilight-cat scene: paces ticks from frame
// pulses, steps NIGHT/RISE/DAY/SET with a shared fade level, and walks the sprite left.
module scene_sequencer #(
    parameter int CORDW      = 16,
    parameter int H_RES      = 640,
    parameter int SPR_DRAWW  = 128,
    parameter int SPR_SPX    = 2,
    parameter int SPR_Y      = 240,
    parameter int FADE_STEP  = 4,
    parameter int HOLD_TICKS = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame,
    input  logic             pause,
    input  logic             step,
    input  logic [1:0]       speed,
    output logic [7:0]       fade_level,
    output logic             direction,
    output logic [1:0]       phase,
    output logic             phase_start,
    output logic [CORDW-1:0] sprx,
    output logic [CORDW-1:0] spry
);

    typedef enum logic [1:0] {
        NIGHT = 2'd0,
        RISE  = 2'd1,
        DAY   = 2'd2,
        SET   = 2'd3
    } phase_t;

    // A zero hold length behaves like a one-tick hold.
    localparam logic [7:0] HOLD_LAST = (HOLD_TICKS <= 1) ? 8'd0 : 8'(HOLD_TICKS - 1);
    localparam logic [8:0] STEP9     = 9'(FADE_STEP);
    localparam logic [7:0] STEP8     = 8'(FADE_STEP);

    localparam logic signed [CORDW-1:0] X_RESET = CORDW'(H_RES);
    localparam logic signed [CORDW-1:0] X_EXIT  = CORDW'(-SPR_DRAWW);
    localparam logic signed [CORDW-1:0] X_STEP  = CORDW'(SPR_SPX);
    localparam logic signed [CORDW-1:0] Y_POS   = CORDW'(SPR_Y);

    phase_t                   phase_q, phase_d;
    logic [7:0]               fade_q, fade_d;
    logic                     dir_q, dir_d;
    logic                     pstart_q, pstart_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [2:0]               pre_q, pre_d;
    logic signed [CORDW-1:0]  sprx_q, sprx_d;

    logic [2:0] mask;
    logic       frame_tick;
    logic       tick;
    logic [8:0] rise_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= NIGHT;
            fade_q   <= 8'd0;
            dir_q    <= 1'b1;
            pstart_q <= 1'b0;
            cnt_q    <= 8'd0;
            pre_q    <= 3'd0;
            sprx_q   <= X_RESET;
        end else begin
            phase_q  <= phase_d;
            fade_q   <= fade_d;
            dir_q    <= dir_d;
            pstart_q <= pstart_d;
            cnt_q    <= cnt_d;
            pre_q    <= pre_d;
            sprx_q   <= sprx_d;
        end
    end

    always_comb begin
        phase_d  = phase_q;
        fade_d   = fade_q;
        cnt_d    = cnt_q;
        sprx_d   = sprx_q;
        pre_d    = pre_q;

        // Prescaler keeps counting across speed changes; only pause freezes it.
        mask       = 3'((4'd1 << speed) - 4'd1);
        frame_tick = frame & ~pause & ((pre_q & mask) == mask);
        tick       = frame_tick | (pause & step);
        rise_sum   = {1'b0, fade_q} + STEP9;

        if (frame && !pause) begin
            pre_d = pre_q + 3'd1;
        end

        if (tick) begin
            unique case (phase_q)
                NIGHT: begin
                    fade_d = 8'd0;
                    if (cnt_q == HOLD_LAST) begin
                        phase_d = RISE;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                RISE: begin
                    if (rise_sum >= 9'd255) begin
                        fade_d  = 8'd255;
                        phase_d = DAY;
                    end else begin
                        fade_d = rise_sum[7:0];
                    end
                end
                DAY: begin
                    fade_d = 8'd255;
                    if (cnt_q == HOLD_LAST) begin
                        phase_d = SET;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                SET: begin
                    if ({1'b0, fade_q} <= STEP9) begin
                        fade_d  = 8'd0;
                        phase_d = NIGHT;
                    end else begin
                        fade_d = fade_q - STEP8;
                    end
                end
            endcase

            if (sprx_q <= X_EXIT) begin
                sprx_d = X_RESET;
            end else begin
                sprx_d = sprx_q - X_STEP;
            end
        end

        dir_d    = (phase_d == NIGHT) || (phase_d == RISE);
        pstart_d = (phase_d != phase_q);
    end

    assign fade_level  = fade_q;
    assign direction   = dir_q;
    assign phase       = phase_q;
    assign phase_start = pstart_q;
    assign sprx        = sprx_q;
    assign spry        = Y_POS;

endmodule
